// File: rtl/load_store_unit_if.sv
// Decoded-op request, data-memory and writeback signals of the load/store unit.
// master: the surrounding pipeline/memory; slave: the load_store_unit itself.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    logic        wb_valid;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_err;

    modport master (
        output req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
        output mem_ack, mem_rdata,
        input  req_ready,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  wb_valid, wb_we, wb_rd, wb_data, wb_err
    );

    modport slave (
        input  req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
        input  mem_ack, mem_rdata,
        output req_ready,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output wb_valid, wb_we, wb_rd, wb_data, wb_err
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one word-wide data-memory transaction per decoded load/store.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned halfword/word accesses instead of truncating.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 0,
    parameter int unsigned TIMEOUT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    load_store_unit_if.slave bus
);

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    state_e               state_q;
    logic [TIMEOUT_W-1:0] cnt_q;

    // Op fields kept for the load-data path and writeback
    logic                 is_store_q;
    logic [2:0]           f3_q;
    logic [1:0]           off_q;
    logic [4:0]           rd_q;

    logic                 req_ready_q;
    logic                 mem_req_q;
    logic                 mem_we_q;
    logic [31:0]          mem_addr_q;
    logic [3:0]           mem_be_q;
    logic [31:0]          mem_wdata_q;
    logic                 wb_valid_q;
    logic                 wb_we_q;
    logic [4:0]           wb_rd_q;
    logic [31:0]          wb_data_q;
    logic                 wb_err_q;

    logic                 legal_c;
    logic                 misalign_c;
    logic [3:0]           st_be_c;
    logic [31:0]          st_wdata_c;
    logic [7:0]           ld_byte_c;
    logic [15:0]          ld_half_c;
    logic [31:0]          ld_data_c;
    logic                 timeout_hit_c;

    // Legality and alignment of the op presented at the request port
    always_comb begin
        legal_c    = 1'b0;
        misalign_c = 1'b0;
        if (bus.req_is_store) begin
            legal_c = bus.req_funct3 inside {F3_SB, F3_SH, F3_SW};
        end else begin
            legal_c = bus.req_funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
        end
        case (bus.req_funct3[1:0])
            2'b01:   misalign_c = TRAP_EN && bus.req_addr[0];
            2'b10:   misalign_c = TRAP_EN && (bus.req_addr[1:0] != 2'b00);
            default: misalign_c = 1'b0;
        endcase
    end

    // Byte enables and lane-replicated data; halfword/word ignore the low offset bits
    always_comb begin
        st_be_c    = 4'b1111;
        st_wdata_c = 32'h0;
        if (bus.req_is_store) begin
            case (bus.req_funct3)
                F3_SB: begin
                    st_be_c    = 4'b0001 << bus.req_addr[1:0];
                    st_wdata_c = {4{bus.req_wdata[7:0]}};
                end
                F3_SH: begin
                    st_be_c    = 4'b0011 << {bus.req_addr[1], 1'b0};
                    st_wdata_c = {2{bus.req_wdata[15:0]}};
                end
                F3_SW: begin
                    st_be_c    = 4'b1111;
                    st_wdata_c = bus.req_wdata;
                end
                default: begin
                    st_be_c    = 4'b1111;
                    st_wdata_c = 32'h0;
                end
            endcase
        end
    end

    // Lane extraction and extension of the returning read data
    always_comb begin
        ld_byte_c = bus.mem_rdata[{off_q, 3'b000} +: 8];
        ld_half_c = bus.mem_rdata[{off_q[1], 4'b0000} +: 16];
        case (f3_q)
            F3_LB:   ld_data_c = {{24{ld_byte_c[7]}}, ld_byte_c};
            F3_LBU:  ld_data_c = {24'h0, ld_byte_c};
            F3_LH:   ld_data_c = {{16{ld_half_c[15]}}, ld_half_c};
            F3_LHU:  ld_data_c = {16'h0, ld_half_c};
            default: ld_data_c = bus.mem_rdata;
        endcase
    end

    assign timeout_hit_c = (TIMEOUT_CYCLES != 0) &&
                           (cnt_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            is_store_q  <= 1'b0;
            f3_q        <= 3'b000;
            off_q       <= 2'b00;
            rd_q        <= 5'd0;
            req_ready_q <= 1'b1;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_be_q    <= 4'h0;
            mem_wdata_q <= 32'h0;
            wb_valid_q  <= 1'b0;
            wb_we_q     <= 1'b0;
            wb_rd_q     <= 5'd0;
            wb_data_q   <= 32'h0;
            wb_err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        is_store_q  <= bus.req_is_store;
                        f3_q        <= bus.req_funct3;
                        off_q       <= bus.req_addr[1:0];
                        rd_q        <= bus.req_rd;
                        req_ready_q <= 1'b0;
                        if (legal_c && !misalign_c) begin
                            state_q     <= ACCESS;
                            cnt_q       <= '0;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= bus.req_is_store;
                            mem_addr_q  <= {bus.req_addr[31:2], 2'b00};
                            mem_be_q    <= st_be_c;
                            mem_wdata_q <= st_wdata_c;
                        end else begin
                            state_q    <= DONE;
                            wb_valid_q <= 1'b1;
                            wb_we_q    <= 1'b0;
                            wb_rd_q    <= bus.req_rd;
                            wb_data_q  <= 32'h0;
                            wb_err_q   <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    if (bus.mem_ack || timeout_hit_c) begin
                        state_q     <= DONE;
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= 32'h0;
                        mem_be_q    <= 4'h0;
                        mem_wdata_q <= 32'h0;
                        wb_valid_q  <= 1'b1;
                        wb_rd_q     <= rd_q;
                        wb_err_q    <= !bus.mem_ack;
                        wb_we_q     <= bus.mem_ack && !is_store_q && (rd_q != 5'd0);
                        wb_data_q   <= (bus.mem_ack && !is_store_q) ? ld_data_c : 32'h0;
                    end else begin
                        cnt_q <= cnt_q + TIMEOUT_W'(1);
                    end
                end
                DONE: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                    wb_valid_q  <= 1'b0;
                    wb_we_q     <= 1'b0;
                    wb_rd_q     <= 5'd0;
                    wb_data_q   <= 32'h0;
                    wb_err_q    <= 1'b0;
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.wb_valid  = wb_valid_q;
    assign bus.wb_we     = wb_we_q;
    assign bus.wb_rd     = wb_rd_q;
    assign bus.wb_data   = wb_data_q;
    assign bus.wb_err    = wb_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: two instances (no timeout / TIMEOUT_CYCLES=2) share stimulus
// and are checked every cycle against an arithmetic reference model plus literal expectations.
module tb_load_store_unit;

    localparam logic [2:0] F3_LB = 3'b000, F3_LH = 3'b001, F3_LW = 3'b010, F3_LD = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100, F3_LHU = 3'b101, F3_LWU = 3'b110;
    localparam logic [2:0] F3_SB = 3'b000, F3_SH = 3'b001, F3_SW = 3'b010, F3_SD = 3'b011;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    typedef struct packed {
        logic        req_ready;
        logic        mem_req;
        logic        mem_we;
        logic [31:0] mem_addr;
        logic [3:0]  mem_be;
        logic [31:0] mem_wdata;
        logic        wb_valid;
        logic        wb_we;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic        wb_err;
    } outs_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_is_store, mem_ack;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata, mem_rdata;
    logic [4:0]  req_rd;

    int vectors = 0;
    int errors  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    load_store_unit_if ifa ();
    load_store_unit_if ifb ();

    load_store_unit #(.TIMEOUT_CYCLES(0), .TIMEOUT_W(8)) dut0 (.clk(clk), .rst(rst), .bus(ifa));
    load_store_unit #(.TIMEOUT_CYCLES(2), .TIMEOUT_W(8)) dut1 (.clk(clk), .rst(rst), .bus(ifb));

    assign ifa.req_valid = req_valid;       assign ifb.req_valid = req_valid;
    assign ifa.req_is_store = req_is_store; assign ifb.req_is_store = req_is_store;
    assign ifa.req_funct3 = req_funct3;     assign ifb.req_funct3 = req_funct3;
    assign ifa.req_addr = req_addr;         assign ifb.req_addr = req_addr;
    assign ifa.req_wdata = req_wdata;       assign ifb.req_wdata = req_wdata;
    assign ifa.req_rd = req_rd;             assign ifb.req_rd = req_rd;
    assign ifa.mem_ack = mem_ack;           assign ifb.mem_ack = mem_ack;
    assign ifa.mem_rdata = mem_rdata;       assign ifb.mem_rdata = mem_rdata;

    outs_t act [2];
    outs_t expv [2];

    assign act[0] = {ifa.req_ready, ifa.mem_req, ifa.mem_we, ifa.mem_addr, ifa.mem_be, ifa.mem_wdata,
                     ifa.wb_valid, ifa.wb_we, ifa.wb_rd, ifa.wb_data, ifa.wb_err};
    assign act[1] = {ifb.req_ready, ifb.mem_req, ifb.mem_we, ifb.mem_addr, ifb.mem_be, ifb.mem_wdata,
                     ifb.wb_valid, ifb.wb_we, ifb.wb_rd, ifb.wb_data, ifb.wb_err};

    task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
        vectors++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, a, e, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int acc_size(input logic [2:0] f3);
        return 1 << int'(f3[1:0]);
    endfunction

    function automatic bit op_ok(input logic st, input logic [2:0] f3, input logic [31:0] a);
        bit legal;
        int sz;
        sz    = acc_size(f3);
        legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        return legal && !(TRAP_EN && (int'(a[1:0]) % sz != 0));
    endfunction

    function automatic logic [3:0] model_be(input logic st, input logic [2:0] f3, input logic [31:0] a);
        int sz, base;
        if (!st) return 4'hF;
        sz   = acc_size(f3);
        base = int'(a[1:0]) / sz * sz;
        return 4'(((1 << sz) - 1) << base);
    endfunction

    function automatic logic [31:0] model_wdata(input logic st, input logic [2:0] f3, input logic [31:0] d);
        if (!st) return 32'h0;
        case (acc_size(f3))
            1:       return (d & 32'hFF) * 32'h0101_0101;
            2:       return (d & 32'hFFFF) * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        int sz, base, bits;
        logic [31:0] v, mask;
        sz = acc_size(f3);
        if (sz == 4) return rd;
        base = int'(a[1:0]) / sz * sz;
        bits = 8 * sz;
        mask = 32'((64'd1 << bits) - 1);
        v    = (rd >> (8 * base)) & mask;
        if (!f3[2] && v[bits-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic outs_t model_wb(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                       input logic [4:0] rd, input logic [31:0] rdata, input bit err);
        outs_t o;
        o          = '0;
        o.wb_valid = 1'b1;
        o.wb_rd    = rd;
        o.wb_err   = err;
        o.wb_we    = !st && !err && (rd != 5'd0);
        o.wb_data  = (st || err) ? 32'h0 : model_load(f3, a, rdata);
        return o;
    endfunction

    int          m_phase [2];
    int          m_wait [2];
    int          m_tmo [2] = '{0, 2};
    logic        m_st [2];
    logic [2:0]  m_f3 [2];
    logic [31:0] m_addr [2];
    logic [4:0]  m_rd [2];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                expv[k]           = '0;
                expv[k].req_ready = 1'b1;
                m_phase[k]        = 0;
            end else if (m_phase[k] == 0) begin
                if (req_valid) begin
                    m_st[k] = req_is_store; m_f3[k] = req_funct3;
                    m_addr[k] = req_addr;   m_rd[k] = req_rd;
                    expv[k].req_ready = 1'b0;
                    if (op_ok(req_is_store, req_funct3, req_addr)) begin
                        m_phase[k]        = 1;
                        m_wait[k]         = 0;
                        expv[k].mem_req   = 1'b1;
                        expv[k].mem_we    = req_is_store;
                        expv[k].mem_addr  = req_addr & ~32'h3;
                        expv[k].mem_be    = model_be(req_is_store, req_funct3, req_addr);
                        expv[k].mem_wdata = model_wdata(req_is_store, req_funct3, req_wdata);
                    end else begin
                        m_phase[k] = 2;
                        expv[k]    = model_wb(req_is_store, req_funct3, req_addr, req_rd, 32'h0, 1'b1);
                    end
                end
            end else if (m_phase[k] == 1) begin
                if (mem_ack) begin
                    m_phase[k] = 2;
                    expv[k]    = model_wb(m_st[k], m_f3[k], m_addr[k], m_rd[k], mem_rdata, 1'b0);
                end else begin
                    m_wait[k]++;
                    if (m_tmo[k] != 0 && m_wait[k] == m_tmo[k]) begin
                        m_phase[k] = 2;
                        expv[k]    = model_wb(m_st[k], m_f3[k], m_addr[k], m_rd[k], 32'h0, 1'b1);
                    end
                end
            end else begin
                m_phase[k]        = 0;
                expv[k]           = '0;
                expv[k].req_ready = 1'b1;
            end
        end
    end

    // Every-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("u%0d.req_ready", k), 32'(act[k].req_ready), 32'(expv[k].req_ready));
                check($sformatf("u%0d.mem_req", k),   32'(act[k].mem_req),   32'(expv[k].mem_req));
                check($sformatf("u%0d.mem_we", k),    32'(act[k].mem_we),    32'(expv[k].mem_we));
                check($sformatf("u%0d.mem_addr", k),  act[k].mem_addr,       expv[k].mem_addr);
                check($sformatf("u%0d.mem_be", k),    32'(act[k].mem_be),    32'(expv[k].mem_be));
                check($sformatf("u%0d.mem_wdata", k), act[k].mem_wdata,      expv[k].mem_wdata);
                check($sformatf("u%0d.wb_valid", k),  32'(act[k].wb_valid),  32'(expv[k].wb_valid));
                check($sformatf("u%0d.wb_we", k),     32'(act[k].wb_we),     32'(expv[k].wb_we));
                check($sformatf("u%0d.wb_rd", k),     32'(act[k].wb_rd),     32'(expv[k].wb_rd));
                check($sformatf("u%0d.wb_data", k),   act[k].wb_data,        expv[k].wb_data);
                check($sformatf("u%0d.wb_err", k),    32'(act[k].wb_err),    32'(expv[k].wb_err));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_idle();
        int n;
        n = 0;
        while (!(ifa.req_ready && ifb.req_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!(ifa.req_ready && ifb.req_ready)) begin
            vectors++;
            errors++;
            $display("FAIL idle_wait: req_ready still low after %0d cycles", n);
        end
    endtask

    // Presents one op for a single cycle; returns at the negedge after the accept edge
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd);
        wait_idle();
        req_valid = 1'b1; req_is_store = st; req_funct3 = f3;
        req_addr = a; req_wdata = wd; req_rd = rd;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic respond(input int delay, input logic [31:0] rdata);
        repeat (delay) @(negedge clk);
        mem_ack = 1'b1; mem_rdata = rdata;
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = 32'h0;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'b0;
        req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0; mem_ack = 1'b0; mem_rdata = 32'h0;
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_req_ready", 32'(ifa.req_ready), 32'd1);
        check("rst_mem_req", 32'(ifa.mem_req), 32'd0);
        check("rst_wb_valid", 32'(ifa.wb_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        // ack while idle must be ignored
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        mem_ack = 1'b0;
        check("idle_ack_ignored", 32'(ifa.wb_valid), 32'd0);

        issue(1'b0, F3_LB, 32'h0000_0103, 32'h0, 5'd5);
        check("lb_mem_be", 32'(ifa.mem_be), 32'hF);
        check("lb_mem_addr", ifa.mem_addr, 32'h0000_0100);
        respond(0, 32'h80FF_1234);
        check("lb_wb_valid", 32'(ifa.wb_valid), 32'd1);
        check("lb_wb_data", ifa.wb_data, 32'hFFFF_FF80);
        check("lb_wb_we", 32'(ifa.wb_we), 32'd1);

        issue(1'b0, F3_LHU, 32'h0000_0202, 32'h0, 5'd6);
        respond(0, 32'hBEEF_0001);
        check("lhu_wb_data", ifa.wb_data, 32'h0000_BEEF);
        issue(1'b0, F3_LH, 32'h0000_0202, 32'h0, 5'd6);
        respond(0, 32'hBEEF_0001);
        check("lh_wb_data", ifa.wb_data, 32'hFFFF_BEEF);

        issue(1'b1, F3_SB, 32'h0000_0301, 32'h1122_33AB, 5'd8);
        check("sb_mem_we", 32'(ifa.mem_we), 32'd1);
        check("sb_mem_be", 32'(ifa.mem_be), 32'b0010);
        check("sb_mem_wdata", ifa.mem_wdata, 32'hABAB_ABAB);
        respond(0, 32'h5555_5555);
        check("sb_wb_we", 32'(ifa.wb_we), 32'd0);
        check("sb_wb_data", ifa.wb_data, 32'h0);
        check("sb_wb_rd", 32'(ifa.wb_rd), 32'd8);

        issue(1'b1, F3_SH, 32'h0000_0402, 32'hCAFE_1357, 5'd1);
        respond(1, 32'h0);
        issue(1'b1, F3_SW, 32'h0000_0404, 32'h0BAD_F00D, 5'd2);
        respond(0, 32'h0);
        issue(1'b0, F3_LBU, 32'h0000_0100, 32'h0, 5'd0);
        respond(0, 32'h0000_00F7);
        check("rd0_wb_we", 32'(ifa.wb_we), 32'd0);
        check("lbu_wb_data", ifa.wb_data, 32'h0000_00F7);

        // Delayed ack on u0; u1 times out after two access cycles
        issue(1'b0, F3_LW, 32'h0000_0500, 32'h0, 5'd7);
        for (int i = 0; i < 3; i++) begin
            check("dly_mem_req", 32'(ifa.mem_req), 32'd1);
            check("dly_req_ready", 32'(ifa.req_ready), 32'd0);
            check("dly_mem_addr", ifa.mem_addr, 32'h0000_0500);
            if (i == 2) begin
                check("tmo_wb_err", 32'(ifb.wb_err), 32'd1);
                check("tmo_mem_req", 32'(ifb.mem_req), 32'd0);
            end
            @(negedge clk);
        end
        check("dly_mem_req_last", 32'(ifa.mem_req), 32'd1);
        respond(0, 32'h1234_5678);
        check("dly_wb_data", ifa.wb_data, 32'h1234_5678);
        check("dly_wb_err", 32'(ifa.wb_err), 32'd0);

        issue(1'b0, F3_LD, 32'h0000_0600, 32'h0, 5'd4);
        check("ld_illegal_err", 32'(ifa.wb_err), 32'd1);
        check("ld_illegal_valid", 32'(ifa.wb_valid), 32'd1);
        check("ld_illegal_mem_req", 32'(ifa.mem_req), 32'd0);
        @(negedge clk);
        issue(1'b1, F3_SD, 32'h0000_0600, 32'h1, 5'd4);
        @(negedge clk);
        issue(1'b0, F3_LWU, 32'h0000_0600, 32'h0, 5'd4);
        @(negedge clk);

        // Reset in the middle of an access, then a late ack
        issue(1'b0, F3_LW, 32'h0000_0700, 32'h0, 5'd3);
        check("rstmid_mem_req", 32'(ifa.mem_req), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstmid_req_ready", 32'(ifa.req_ready), 32'd1);
        check("rstmid_mem_req_drop", 32'(ifa.mem_req), 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        mem_ack = 1'b0;
        check("rstmid_late_ack", 32'(ifa.wb_valid), 32'd0);

        issue(1'b0, F3_LW, 32'h0000_0102, 32'h0, 5'd9);
`ifdef LSU_MISALIGN_TRAP_EN
        check("mis_lw_err", 32'(ifa.wb_err), 32'd1);
        check("mis_lw_mem_req", 32'(ifa.mem_req), 32'd0);
        @(negedge clk);
`else
        check("mis_lw_mem_addr", ifa.mem_addr, 32'h0000_0100);
        respond(0, 32'hCAFE_F00D);
        check("mis_lw_wb_data", ifa.wb_data, 32'hCAFE_F00D);
        check("mis_lw_wb_err", 32'(ifa.wb_err), 32'd0);
`endif
        issue(1'b1, F3_SH, 32'h0000_0203, 32'h0000_A55A, 5'd10);
        respond(0, 32'h0);
        issue(1'b0, F3_LH, 32'h0000_0201, 32'h0, 5'd11);
        respond(0, 32'h0000_8001);

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-access stage downstream of instruction decode. Takes a decoded load/store (funct3 from the shared definitions package: F3_LB..F3_LHU, F3_SB..F3_SW) and runs one word-wide data-memory transaction with a req/ack handshake. Generates byte enables and lane-replicated store data, and extracts, aligns and sign/zero-extends load data. Produces a single-cycle writeback result for the register-file stage.

Parameters:
TIMEOUT_CYCLES, 0, cycles to wait for mem_ack before aborting; 0 disables the timeout (wait forever)
TIMEOUT_W, 8, width of the timeout counter; TIMEOUT_CYCLES must be < 2**TIMEOUT_W

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
req_valid  in  1  decoded memory op presented
req_ready  out  1  unit idle and able to accept an op
req_is_store  in  1  1 = store (OP_STORE), 0 = load (OP_LOAD)
req_funct3  in  3  funct3 field of the instruction
req_addr  in  32  effective byte address (rs1 + imm)
req_wdata  in  32  rs2 value for stores
req_rd  in  5  destination register for loads
mem_req  out  1  memory transaction active
mem_we  out  1  write strobe
mem_addr  out  32  word address: req_addr with bits [1:0] forced to 0
mem_be  out  4  byte enables
mem_wdata  out  32  lane-replicated store data
mem_ack  in  1  memory completes the transaction this cycle
mem_rdata  in  32  read data, valid when mem_ack = 1
wb_valid  out  1  one-cycle completion pulse
wb_we  out  1  register write required (load, rd != 0, no error)
wb_rd  out  5  destination register
wb_data  out  32  extended load data; 0 for stores and errors
wb_err  out  1  op aborted: illegal funct3, misaligned access (see macro), or timeout

Behaviour:
- Reset value of all outputs is 0, except req_ready, which is 1. The FSM resets to IDLE and the timeout counter resets to 0.
- FSM states: IDLE, ACCESS, DONE. req_ready = (state == IDLE).
- IDLE: when req_valid & req_ready, latch the op.
  - Legal op: move to ACCESS.
  - Illegal op: move to DONE with the error flag set and no memory access.
  - Legal loads: funct3 000, 001, 010, 100, 101. Legal stores: funct3 000, 001, 010. F3_LD, F3_LWU, F3_SD and all other codes are illegal.
- ACCESS: mem_req = 1 and all mem_* outputs are stable for the whole state.
  - On mem_ack, capture mem_rdata and move to DONE.
  - If TIMEOUT_CYCLES > 0 and the counter reaches TIMEOUT_CYCLES without an ack, move to DONE with the error flag set.
  - The counter clears on entry to ACCESS.
- DONE: wb_* driven for exactly one cycle, then IDLE. A new op can be accepted no earlier than the cycle after DONE.
- Latency, from the accept edge: mem_req is high in cycle +1. With an ack in the same cycle, wb_valid is high in cycle +2. Each cycle without an ack adds one cycle.
- mem_ack is ignored in IDLE and DONE.
- Byte lane off = addr[1:0].
  - Stores:
    - SB: be = 4'b0001 << off, wdata = {4{rs2[7:0]}}.
    - SH: be = 4'b0011 << (2*addr[1]), wdata = {2{rs2[15:0]}}.
    - SW: be = 4'b1111, wdata = rs2.
  - Loads: be = 4'b1111, mem_we = 0.
    - LB/LBU: take rdata[8*off +: 8], sign- or zero-extend.
    - LH/LHU: take rdata[16*addr[1] +: 16], sign- or zero-extend.
    - LW: take rdata as is.
- wb_we = load & !err & (rd != 0).
- wb_rd is the latched rd, also for stores.
- Reset during ACCESS: next edge goes to IDLE and mem_req drops. A late mem_ack is ignored and no wb_valid is produced.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: a halfword with addr[0] = 1, or a word with addr[1:0] != 0, goes to DONE with wb_err = 1 and no memory access.
- Undefined: misaligned addresses are truncated to natural alignment. Halfword ignores addr[0]; word ignores addr[1:0]. The access proceeds normally and wb_err is never raised for alignment.

Test Plan:
- LB at addr 0x103, mem_rdata = 0x80FF_1234 with immediate ack -> mem_be = 4'b1111, mem_addr = 0x100, wb_valid two cycles after accept, wb_data = 0xFFFF_FF80, wb_we = 1.
- LHU at 0x202 with rdata 0xBEEF_0001 -> wb_data = 0x0000_BEEF. LH at the same address and data -> 0xFFFF_BEEF.
- SB at 0x301, rs2 = 0x1122_33AB -> mem_we = 1, mem_be = 4'b0010, mem_wdata = 0xABAB_ABAB, wb_we = 0, wb_data = 0.
- Ack delayed 3 cycles -> mem_req held with stable addr/be/wdata for 4 cycles, req_ready = 0 throughout. With TIMEOUT_CYCLES = 2 and no ack -> wb_err = 1, mem_req drops.
- funct3 = 011 load -> no mem_req, wb_valid + wb_err one cycle after accept. rst asserted mid-ACCESS -> all outputs 0, req_ready = 1 next cycle, subsequent ack ignored.
- LW at 0x102 -> with LSU_MISALIGN_TRAP_EN: wb_err = 1 and no mem_req. Without: mem_addr = 0x100, normal load.
